// File: rtl/signed_muldiv_seq_pkg.sv
// Shared encodings for signed_muldiv_seq.
//   op codes : OP_MULU / OP_MULS / OP_DIVU / OP_DIVS (bit1 = divide, bit0 = signed)
//   state_t  : sequencer states
package signed_muldiv_seq_pkg;
  localparam logic [1:0] OP_MULU = 2'b00;
  localparam logic [1:0] OP_MULS = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_DIVS = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction
endpackage

// File: rtl/signed_muldiv_seq_if.sv
// Request/response bundle for signed_muldiv_seq.
//   master: drives start/op/narrow/a/b, observes busy/done/hi/lo/div0/ovf
//   slave : the arithmetic unit
interface signed_muldiv_seq_if #(parameter int W = 16);
  logic         start;
  logic [1:0]   op;
  logic         narrow;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div0;
  logic         ovf;

  modport master (output start, op, narrow, a, b,
                  input  busy, done, hi, lo, div0, ovf);
  modport slave  (input  start, op, narrow, a, b,
                  output busy, done, hi, lo, div0, ovf);
endinterface

// File: rtl/signed_muldiv_seq_cond_neg.sv
// cond_neg: conditional two's-complement negation.
//   neg : 1 = output -d, 0 = output d
//   d   : WD-bit input, q : WD-bit result
module cond_neg #(parameter int WD = 16) (
  input  logic          neg,
  input  logic [WD-1:0] d,
  output logic [WD-1:0] q
);
  assign q = neg ? (~d + {{(WD-1){1'b0}}, 1'b1}) : d;
endmodule

// File: rtl/signed_muldiv_seq.sv
// signed_muldiv_seq: iterative signed/unsigned multiply and divide.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of signed_muldiv_seq_if (start/op/narrow/a/b in,
//                busy/done/hi/lo/div0/ovf out)
// Sequence: IDLE -> PREP (magnitudes) -> RUN (N steps) -> FIX (signs) -> DONE,
// with done/results registered on the DONE->IDLE edge.
module signed_muldiv_seq
  import signed_muldiv_seq_pkg::*;
#(parameter int W = 16) (
  input logic                clk,
  input logic                rst_n,
  signed_muldiv_seq_if.slave bus
);
  localparam int H  = W / 2;
  localparam int CW = $clog2(W) + 1;

  state_t         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic           nar_q, nar_d, sa_q, sa_d, sb_q, sb_d, dz_q, dz_d, ov_q, ov_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, mq_q, mq_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d, done_q, done_d, div0_q, div0_d, ovf_q, ovf_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic           is_sgn, is_div, sa, sb;
  logic [W-1:0]   a_ext, b_ext, a_mag, b_mag, min_ext, rem_s, quot;
  logic [2*W-1:0] mul_step, div_step, fix_in, fix_p;
  logic [W:0]     trial;

  assign is_sgn = op_is_signed(op_q);
  assign is_div = op_is_div(op_q);

  // Narrow mode works on the low half, extended to W so one datapath serves both.
  assign a_ext = nar_q ? {{H{is_sgn & a_q[H-1]}}, a_q[H-1:0]} : a_q;
  assign b_ext = nar_q ? {{H{is_sgn & b_q[H-1]}}, b_q[H-1:0]} : b_q;
  assign sa    = is_sgn & a_ext[W-1];
  assign sb    = is_sgn & b_ext[W-1];
  assign min_ext = nar_q ? {{(H+1){1'b1}}, {(H-1){1'b0}}} : {1'b1, {(W-1){1'b0}}};

  cond_neg #(.WD(W)) u_neg_a (.neg(sa), .d(a_ext), .q(a_mag));
  cond_neg #(.WD(W)) u_neg_b (.neg(sb), .d(b_ext), .q(b_mag));

  // Multiply: MSB-first shift-add; multiplier bits are pre-aligned to mq_q[W-1].
  assign mul_step = {acc_q[2*W-2:0], 1'b0} + (mq_q[W-1] ? {{W{1'b0}}, a_q} : '0);

  // Divide: acc = {remainder, dividend/quotient}; restoring step on shifted pair.
  assign trial    = acc_q[2*W-1:W-1] - {1'b0, b_q};
  assign div_step = trial[W] ? {acc_q[2*W-2:0], 1'b0}
                             : {trial[W-1:0], acc_q[W-2:0], 1'b1};

  assign fix_in = is_div ? {{W{1'b0}}, acc_q[W-1:0]} : acc_q;
  cond_neg #(.WD(2*W)) u_fix (.neg(sa_q ^ sb_q), .d(fix_in), .q(fix_p));
  cond_neg #(.WD(W))   u_rem (.neg(sa_q), .d(acc_q[2*W-1:W]), .q(rem_s));

  // Narrow signed quotient re-extends from bit H-1 so the overflow case wraps.
  always_comb begin
    quot = fix_p[W-1:0];
    if (nar_q && is_sgn) quot = {{H{fix_p[H-1]}}, fix_p[H-1:0]};
  end

  always_comb begin
    state_d = state_q; op_d = op_q; nar_d = nar_q; a_d = a_q; b_d = b_q;
    mq_d = mq_q; acc_d = acc_q; cnt_d = cnt_q; sa_d = sa_q; sb_d = sb_q;
    dz_d = dz_q; ov_d = ov_q; busy_d = busy_q; done_d = 1'b0;
    div0_d = div0_q; ovf_d = ovf_q; hi_d = hi_q; lo_d = lo_q;
    unique case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_PREP; op_d = bus.op; nar_d = bus.narrow;
        a_d = bus.a; b_d = bus.b; busy_d = 1'b1; div0_d = 1'b0; ovf_d = 1'b0;
      end
      S_PREP: begin
        a_d = a_mag; b_d = b_mag; sa_d = sa; sb_d = sb;
        cnt_d = nar_q ? CW'(H) : CW'(W);
        dz_d = is_div & (b_ext == '0);
        ov_d = is_div & is_sgn & (a_ext == min_ext) & (&b_ext);
        mq_d = nar_q ? {b_mag[H-1:0], {H{1'b0}}} : b_mag;
        if (is_div) acc_d = nar_q ? {{W{1'b0}}, a_mag[H-1:0], {H{1'b0}}}
                                  : {{W{1'b0}}, a_mag};
        else        acc_d = '0;
        if (is_div && b_ext == '0) begin
          acc_d   = {a_ext, {W{1'b1}}};
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = is_div ? div_step : mul_step;
        mq_d  = {mq_q[W-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        acc_d   = is_div ? {rem_s, quot} : fix_p;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE; done_d = 1'b1; busy_d = 1'b0;
        hi_d = acc_q[2*W-1:W]; lo_d = acc_q[W-1:0];
        div0_d = dz_q; ovf_d = ov_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE; op_q <= '0; nar_q <= 1'b0; a_q <= '0; b_q <= '0;
      mq_q <= '0; acc_q <= '0; cnt_q <= '0; sa_q <= 1'b0; sb_q <= 1'b0;
      dz_q <= 1'b0; ov_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0;
      div0_q <= 1'b0; ovf_q <= 1'b0; hi_q <= '0; lo_q <= '0;
    end else begin
      state_q <= state_d; op_q <= op_d; nar_q <= nar_d; a_q <= a_d; b_q <= b_d;
      mq_q <= mq_d; acc_q <= acc_d; cnt_q <= cnt_d; sa_q <= sa_d; sb_q <= sb_d;
      dz_q <= dz_d; ov_q <= ov_d; busy_q <= busy_d; done_q <= done_d;
      div0_q <= div0_d; ovf_q <= ovf_d; hi_q <= hi_d; lo_q <= lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.div0 = div0_q;
  assign bus.ovf  = ovf_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_signed_muldiv_seq.sv
module tb_signed_muldiv_seq;
  import signed_muldiv_seq_pkg::*;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  signed_muldiv_seq_if #(.W(W)) bus ();
  signed_muldiv_seq #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference: plain integer arithmetic on the M-bit interpreted operands.
  task automatic model(input logic [1:0] op, input logic nar, input logic [W-1:0] a, b,
                       output logic [W-1:0] hi, lo, output logic dz, ov, output int lat);
    int m;
    longint one, mask, av, bv, p, q, r;
    logic [63:0] pv;
    m = nar ? W/2 : W;
    one = 1;
    mask = (one << m) - 1;
    av = longint'(a) & mask;
    bv = longint'(b) & mask;
    if (op[0]) begin
      if (av >= (one << (m-1))) av -= (one << m);
      if (bv >= (one << (m-1))) bv -= (one << m);
    end
    dz = 1'b0; ov = 1'b0; lat = m + 3;
    if (!op[1]) begin
      p = av * bv; pv = p;
      if (nar) begin
        lo = pv[W-1:0];
        hi = (op[0] && p < 0) ? '1 : '0;
      end else begin
        hi = pv[2*W-1:W]; lo = pv[W-1:0];
      end
    end else if (bv == 0) begin
      dz = 1'b1; lat = 2; lo = '1; pv = av; hi = pv[W-1:0];
    end else begin
      ov = op[0] && bv == -1 && av == -(one << (m-1));
      q = (av / bv) & mask;
      r = (av % bv) & mask;
      if (op[0] && q >= (one << (m-1))) q -= (one << m);
      if (op[0] && r >= (one << (m-1))) r -= (one << m);
      pv = q; lo = pv[W-1:0];
      pv = r; hi = pv[W-1:0];
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic nar, input logic [W-1:0] a, b,
                       input logic hold_start);
    logic [W-1:0] ehi, elo;
    logic edz, eov;
    int elat, lat, extra;
    model(op, nar, a, b, ehi, elo, edz, eov, elat);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.narrow = nar; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    if (!hold_start) bus.start = 1'b0;
    // Operand changes after acceptance must be ignored.
    bus.op = 2'($urandom); bus.narrow = 1'($urandom);
    bus.a = W'($urandom); bus.b = W'($urandom);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) chk("busy_after_start", bus.busy, 1'b1);
      if (bus.done) begin lat = k; break; end
    end
    bus.start = 1'b0;
    chk("latency", lat, elat);
    chk("busy_at_done", bus.busy, 1'b0);
    chk("hi", bus.hi, ehi);
    chk("lo", bus.lo, elo);
    chk("div0", bus.div0, edz);
    chk("ovf", bus.ovf, eov);
    @(posedge clk); #1;
    chk("done_one_cycle", bus.done, 1'b0);
    if (hold_start) begin
      extra = 0;
      for (int k = 0; k < 30; k++) begin
        @(posedge clk); #1;
        if (bus.done) extra++;
      end
      chk("no_queued_done", extra, 0);
    end
  endtask

  initial begin
    logic [1:0] op;
    logic nar;
    logic [W-1:0] a, b;
    int nd;
    bus.start = 1'b0; bus.op = '0; bus.narrow = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_hilo", {bus.hi, bus.lo}, '0);
    chk("rst_flags", {bus.div0, bus.ovf}, 2'b00);
    @(negedge clk) rst_n = 1'b1;

    do_op(OP_MULS, 1'b0, 16'hFFFD, 16'h0007, 1'b0);
    do_op(OP_DIVU, 1'b0, 16'd100, 16'd7, 1'b0);
    do_op(OP_DIVS, 1'b0, 16'hFF9C, 16'd7, 1'b0);
    do_op(OP_DIVS, 1'b0, 16'h0005, 16'h0000, 1'b0);
    do_op(OP_DIVS, 1'b0, 16'h8000, 16'hFFFF, 1'b0);
    do_op(OP_MULS, 1'b1, 16'h00FF, 16'h0002, 1'b0);
    do_op(OP_DIVS, 1'b1, 16'h1280, 16'h34FF, 1'b0);
    do_op(OP_DIVU, 1'b1, 16'hAB00, 16'h7700, 1'b0);
    do_op(OP_MULU, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
    do_op(OP_MULS, 1'b0, 16'h8000, 16'h8000, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom); nar = 1'($urandom);
      a = W'($urandom); b = W'($urandom);
      if ($urandom_range(0, 7) == 0) b = nar ? (b & 16'hFF00) : '0;
      do_op(op, nar, a, b, 1'b0);
    end

    // start held high through busy and DONE: only one result.
    do_op(OP_DIVS, 1'b0, 16'h1234, 16'hFFF3, 1'b1);

    // Reset in the middle of RUN.
    do_op(OP_MULU, 1'b0, 16'h1234, 16'h5678, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULU; bus.narrow = 1'b0; bus.a = 16'h00FF; bus.b = 16'h00FF;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    chk("midrst_hilo", {bus.hi, bus.lo}, '0);
    chk("midrst_flags", {bus.div0, bus.ovf}, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (bus.done) nd++;
    end
    chk("midrst_no_done", nd, 0);
    do_op(OP_MULS, 1'b1, 16'h0080, 16'h0080, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/signed_muldiv_seq.md
SIGNED_MULDIV_SEQ -- requirements
Module: signed_muldiv_seq

Interface
REQ-001 Parameter W, default 16, full operand width; SHALL be even and >= 4.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 start  in  1  request; sampled only in IDLE.
REQ-005 op  in  2  00 unsigned mul, 01 signed mul, 10 unsigned div, 11 signed div.
REQ-006 narrow  in  1  1 = operate on a[W/2-1:0], b[W/2-1:0] only.
REQ-007 a  in  W  multiplicand / dividend.
REQ-008 b  in  W  multiplier / divisor.
REQ-009 busy  out  1  high from cycle after accepted start until done cycle, exclusive.
REQ-010 done  out  1  one-cycle pulse; results valid from this cycle.
REQ-011 hi  out  W  mul: product upper half; div: remainder.
REQ-012 lo  out  W  mul: product lower half; div: quotient.
REQ-013 div0  out  1  divide by zero on last op; ovf  out  1  signed-div overflow on last op.

Function
REQ-014 FSM states IDLE, PREP, RUN, FIX, DONE; start in IDLE -> PREP; PREP -> RUN (or DONE on div0); RUN -> FIX after N iterations; FIX -> DONE; DONE -> IDLE.
REQ-015 N = W (narrow=0) or W/2 (narrow=1); active width M = N.
REQ-016 Operands, op and narrow SHALL be latched at start acceptance; later input changes have no effect.
REQ-017 PREP: signed ops take magnitudes of M-bit operands and record sA, sB; unsigned ops use operands as-is.
REQ-018 RUN mul: one shift-add step per cycle, unsigned magnitudes, 2M-bit product.
REQ-019 RUN div: one restoring-division step per cycle, M-bit quotient and remainder.
REQ-020 FIX: signed mul negates product if sA^sB; signed div negates quotient if sA^sB, remainder takes sign of dividend (sA).
REQ-021 Latency: done asserted exactly N+3 cycles after start-sample edge (W=16: 19; narrow: 11).
REQ-022 Full-width mul result {hi,lo} = 2W-bit product; narrow mul: lo = W-bit product, hi = sign-extension (signed) or zero (unsigned).
REQ-023 Narrow div: quotient/remainder in low M bits, sign-extended (signed) or zero-extended (unsigned) to W.
REQ-024 Divisor zero (M-bit): PREP -> DONE, done 2 cycles after start, lo = all ones (W bits), hi = dividend (extended as REQ-023), div0=1.
REQ-025 Signed div, dividend = most-negative M-bit, divisor = -1: quotient = most-negative (wraps), remainder 0, ovf=1.
REQ-026 start while busy or in DONE SHALL be ignored, no queuing.
REQ-027 hi, lo, div0, ovf SHALL hold last values until next done; div0/ovf cleared at next accepted start.
REQ-028 done SHALL never assert for two consecutive cycles.

Reset
REQ-029 rst_n low SHALL immediately force IDLE; busy, done, div0, ovf = 0; hi, lo = 0.
REQ-030 Reset mid-operation SHALL abort with no done pulse; first start after release behaves as from power-up.

Structure
REQ-031 Shared package holds op encodings (OP_MULU, OP_MULS, OP_DIVU, OP_DIVS) and FSM state encodings.
REQ-032 One sub-module cond_neg (parametrised width, conditional two's-complement) SHALL be reused for PREP magnitudes and FIX correction.
REQ-033 Iteration counter width SHALL be clog2(W)+1; no multiplier/divider operators inferred.

Verification (W=16)
REQ-034 op=01, a=16'hFFFD, b=16'h0007 -> hi=16'hFFFF, lo=16'hFFEB, done at cycle 19.
REQ-035 op=10, a=100, b=7 -> lo=14, hi=2; op=11, a=-100, b=7 -> lo=16'hFFF2, hi=16'hFFFE.
REQ-036 op=11, a=16'h0005, b=0 -> div0=1, lo=16'hFFFF, hi=16'h0005, done at cycle 2.
REQ-037 op=11, a=16'h8000, b=16'hFFFF -> lo=16'h8000, hi=0, ovf=1.
REQ-038 narrow=1, op=01, a=16'h00FF, b=16'h0002 -> lo=16'hFFFE, hi=16'hFFFF, done at cycle 11.
REQ-039 rst_n low at RUN cycle 5 -> busy=0, outputs 0 same cycle, no done; start during busy produces no second done.
